// File: rtl/systolic_sched_3x3.sv
// Sequencer for a 3x3 output-stationary systolic MAC array: buffers A/B operands,
// clears the array, then streams skewed A rows west and B columns north.
module systolic_sched_3x3 #(
  parameter int DATAWIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [3:0]               wr_addr,
  input  logic [DATAWIDTH-1:0]     wr_data,
  input  logic                     start,
  output logic                     arr_rstn,
  output logic [3*DATAWIDTH-1:0]   a_west,
  output logic [3*DATAWIDTH-1:0]   b_north,
  output logic                     busy,
  output logic                     done,
  output logic                     result_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;
  logic [2:0]           t_r;
  logic [2:0]           t_nx_s;
  logic                 start_ok_s;
  logic                 wr_ok_s;
  logic [DATAWIDTH-1:0] a_buf_r [0:8];
  logic [DATAWIDTH-1:0] b_buf_r [0:8];
  logic [3*DATAWIDTH-1:0] a_west_nx_s;
  logic [3*DATAWIDTH-1:0] b_north_nx_s;

  // Next-state and feed-counter logic
  always_comb begin
    state_nx_s = state_r;
    t_nx_s     = t_r;
    start_ok_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = CLEAR;
          start_ok_s = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CLEAR: begin
        state_nx_s = FEED;
        t_nx_s     = 3'd0;
      end
      FEED: begin
        if (t_r == 3'd6) begin
          state_nx_s = DONE;
        end else begin
          t_nx_s = t_r + 3'd1;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
        t_nx_s     = 3'd0;
      end
    endcase
  end

  assign wr_ok_s = wr_en && ((state_r == IDLE) || (state_r == DONE)) && (wr_addr <= 4'd8);

  // Edge data for the upcoming cycle: row i carries A[i][t-i], column j carries B[t-j][j]
  always_comb begin
    a_west_nx_s  = '0;
    b_north_nx_s = '0;
    if (state_nx_s == FEED) begin
      for (int i = 0; i < 3; i++) begin
        if ((t_nx_s >= 3'(i)) && (t_nx_s <= 3'(i + 2))) begin
          a_west_nx_s[i*DATAWIDTH +: DATAWIDTH]  = a_buf_r[4'(int'(t_nx_s) + 2*i)];
          b_north_nx_s[i*DATAWIDTH +: DATAWIDTH] = b_buf_r[4'(3*int'(t_nx_s) - 2*i)];
        end else begin
          a_west_nx_s[i*DATAWIDTH +: DATAWIDTH]  = '0;
          b_north_nx_s[i*DATAWIDTH +: DATAWIDTH] = '0;
        end
      end
    end else begin
      a_west_nx_s  = '0;
      b_north_nx_s = '0;
    end
  end

  // State register and registered outputs, all derived from the next state
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_r      <= IDLE;
      t_r          <= 3'd0;
      arr_rstn     <= 1'b0;
      a_west       <= '0;
      b_north      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      t_r      <= t_nx_s;
      arr_rstn <= (state_nx_s != CLEAR);
      a_west   <= a_west_nx_s;
      b_north  <= b_north_nx_s;
      busy     <= (state_nx_s == CLEAR) || (state_nx_s == FEED);
      done     <= (state_nx_s == DONE);
      if (start_ok_s) begin
        result_valid <= 1'b0;
      end else if (state_nx_s == DONE) begin
        result_valid <= 1'b1;
      end else begin
        result_valid <= result_valid;
      end
    end
  end

  // Operand buffers; host writes land only while the array is not being fed
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      for (int k = 0; k < 9; k++) begin
        a_buf_r[k] <= '0;
        b_buf_r[k] <= '0;
      end
    end else if (wr_ok_s) begin
      if (wr_sel) begin
        b_buf_r[wr_addr] <= wr_data;
      end else begin
        a_buf_r[wr_addr] <= wr_data;
      end
    end else begin
      for (int k = 0; k < 9; k++) begin
        a_buf_r[k] <= a_buf_r[k];
        b_buf_r[k] <= b_buf_r[k];
      end
    end
  end

endmodule

// File: tb/tb_systolic_sched_3x3.sv
// Directed bench for systolic_sched_3x3: drives the sequencer into a small
// behavioural 3x3 PE array and checks edge skew, timing flags and products.
module tb_systolic_sched_3x3;

  logic        CLK;
  logic        RSTn;
  logic        wr_en;
  logic        wr_sel;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        start;
  logic        arr_rstn;
  logic [23:0] a_west;
  logic [23:0] b_north;
  logic        busy;
  logic        done;
  logic        result_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  ma    [0:8];
  logic [7:0]  mb    [0:8];
  logic [16:0] exp_c [0:8];
  logic [7:0]  tmp_a [0:8];
  logic [7:0]  tmp_b [0:8];

  systolic_sched_3x3 #(.DATAWIDTH(8)) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .arr_rstn     (arr_rstn),
    .a_west       (a_west),
    .b_north      (b_north),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // PE array model: 17-bit accumulators, operands pass east/south one hop per cycle
  logic [8:0][7:0]  a_q;
  logic [8:0][7:0]  b_q;
  logic [8:0][16:0] acc;

  function automatic logic [7:0] a_at(int i, int j);
    if (j == 0) return a_west[i*8 +: 8];
    else        return a_q[i*3 + j - 1];
  endfunction

  function automatic logic [7:0] b_at(int i, int j);
    if (i == 0) return b_north[j*8 +: 8];
    else        return b_q[(i-1)*3 + j];
  endfunction

  always @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (!arr_rstn) begin
          a_q[i*3+j] <= 8'd0;
          b_q[i*3+j] <= 8'd0;
          acc[i*3+j] <= 17'd0;
        end else begin
          a_q[i*3+j] <= a_at(i, j);
          b_q[i*3+j] <= b_at(i, j);
          acc[i*3+j] <= acc[i*3+j] + 17'(a_at(i, j)) * 17'(b_at(i, j));
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [23:0] exp_west(int t);
    logic [23:0] v;
    v = 24'd0;
    for (int i = 0; i < 3; i++)
      if (t - i >= 0 && t - i <= 2) v[i*8 +: 8] = ma[i*3 + t - i];
    return v;
  endfunction

  function automatic logic [23:0] exp_north(int t);
    logic [23:0] v;
    v = 24'd0;
    for (int j = 0; j < 3; j++)
      if (t - j >= 0 && t - j <= 2) v[j*8 +: 8] = mb[(t - j)*3 + j];
    return v;
  endfunction

  task automatic write_one(input logic sel, input logic [3:0] addr, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    step();
    wr_en = 1'b0;
  endtask

  task automatic load_mats();
    for (int k = 0; k < 9; k++) begin
      ma[k] = tmp_a[k];
      mb[k] = tmp_b[k];
      write_one(1'b0, 4'(k), tmp_a[k]);
      write_one(1'b1, 4'(k), tmp_b[k]);
    end
  endtask

  // Starts in cycle S, ends in cycle S+9 (DONE); st_at/wr_at inject start/write at S+n
  task automatic run_mult(input bit skew, input int st_at, input int wr_at,
                          input logic wsel, input logic [3:0] waddr, input logic [7:0] wdata);
    start = 1'b1;
    wr_sel = wsel; wr_addr = waddr; wr_data = wdata;
    wr_en = (wr_at == 0);
    for (int c = 1; c <= 9; c++) begin
      step();
      start = (c == st_at);
      wr_en = (c == wr_at);
      check_eq($sformatf("busy S+%0d", c), {31'd0, busy}, {31'd0, (c <= 8)});
      check_eq($sformatf("done S+%0d", c), {31'd0, done}, {31'd0, (c == 9)});
      check_eq($sformatf("arr_rstn S+%0d", c), {31'd0, arr_rstn}, {31'd0, (c != 1)});
      if (skew || c == 1 || c == 9) begin
        check_eq($sformatf("a_west S+%0d", c), {8'd0, a_west},
                 {8'd0, ((c >= 2 && c <= 8) ? exp_west(c - 2) : 24'd0)});
        check_eq($sformatf("b_north S+%0d", c), {8'd0, b_north},
                 {8'd0, ((c >= 2 && c <= 8) ? exp_north(c - 2) : 24'd0)});
      end
      if (c == 1) check_eq("result_valid cleared", {31'd0, result_valid}, 32'd0);
    end
    check_eq("result_valid set", {31'd0, result_valid}, 32'd1);
    for (int k = 0; k < 9; k++)
      check_eq($sformatf("pe_acc[%0d]", k), {15'd0, acc[k]}, {15'd0, exp_c[k]});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      start = 1'b0;
      wr_en = 1'b0;
    end
  endtask

  initial begin
    RSTn = 1'b0; start = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd0;
    step(); step();
    check_eq("rst arr_rstn", {31'd0, arr_rstn}, 32'd0);
    check_eq("rst busy", {31'd0, busy}, 32'd0);
    check_eq("rst done", {31'd0, done}, 32'd0);
    check_eq("rst result_valid", {31'd0, result_valid}, 32'd0);
    check_eq("rst a_west", {8'd0, a_west}, 32'd0);
    check_eq("rst b_north", {8'd0, b_north}, 32'd0);
    RSTn = 1'b1;
    step();
    check_eq("post-rst arr_rstn", {31'd0, arr_rstn}, 32'd1);

    // Identity: A = I, B = 1..9; out-of-range addresses must not alias into A
    tmp_a = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    tmp_b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    load_mats();
    write_one(1'b0, 4'd9,  8'h55);
    write_one(1'b0, 4'd15, 8'h66);
    exp_c = '{17'd1, 17'd2, 17'd3, 17'd4, 17'd5, 17'd6, 17'd7, 17'd8, 17'd9};
    run_mult(1'b1, -1, -1, 1'b0, 4'd0, 8'd0);
    idle(1);

    // General product A = 1..9, B = 9..1; result held through idle cycles
    tmp_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    tmp_b = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    load_mats();
    exp_c = '{17'd30, 17'd24, 17'd18, 17'd84, 17'd69, 17'd54, 17'd138, 17'd114, 17'd90};
    run_mult(1'b1, -1, -1, 1'b0, 4'd0, 8'd0);
    idle(4);
    check_eq("result_valid held", {31'd0, result_valid}, 32'd1);
    check_eq("edges quiet a", {8'd0, a_west}, 32'd0);
    check_eq("acc stable [4]", {15'd0, acc[4]}, 32'd69);

    // Accumulator wrap: 3*255*255 mod 2^17
    for (int k = 0; k < 9; k++) begin tmp_a[k] = 8'd255; tmp_b[k] = 8'd255; end
    load_mats();
    for (int k = 0; k < 9; k++) exp_c[k] = 17'd64003;
    run_mult(1'b1, -1, -1, 1'b0, 4'd0, 8'd0);
    idle(1);

    // Start at S+4 and a write at S+5 must both be ignored; rerun confirms buffer intact
    run_mult(1'b0, 4, 5, 1'b0, 4'd0, 8'h11);
    idle(2);
    check_eq("no restart busy", {31'd0, busy}, 32'd0);
    run_mult(1'b0, -1, -1, 1'b0, 4'd0, 8'd0);
    idle(1);

    // Reset during FEED
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    RSTn = 1'b0;
    step();
    check_eq("abort busy", {31'd0, busy}, 32'd0);
    check_eq("abort done", {31'd0, done}, 32'd0);
    check_eq("abort arr_rstn", {31'd0, arr_rstn}, 32'd0);
    check_eq("abort a_west", {8'd0, a_west}, 32'd0);
    check_eq("abort b_north", {8'd0, b_north}, 32'd0);
    check_eq("abort result_valid", {31'd0, result_valid}, 32'd0);
    step();
    check_eq("abort no done", {31'd0, done}, 32'd0);
    RSTn = 1'b1;
    step();
    check_eq("release arr_rstn", {31'd0, arr_rstn}, 32'd1);
    check_eq("release done", {31'd0, done}, 32'd0);
    tmp_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    tmp_b = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    load_mats();
    exp_c = '{17'd30, 17'd24, 17'd18, 17'd84, 17'd69, 17'd54, 17'd138, 17'd114, 17'd90};
    // Back-to-back: B[0][0]=1 written in DONE, B[2][2]=5 written with the next start at S+10
    run_mult(1'b0, -1, 9, 1'b1, 4'd0, 8'd1);
    idle(1);
    mb[0] = 8'd1;
    mb[8] = 8'd5;
    exp_c = '{17'd22, 17'd24, 17'd30, 17'd52, 17'd69, 17'd78, 17'd82, 17'd114, 17'd126};
    run_mult(1'b1, -1, 0, 1'b1, 4'd8, 8'd5);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_sched_3x3.md
# systolic_sched_3x3

Sequencer for the 3x3 output-stationary systolic array of multiply-accumulate PEs. It holds a 3x3 A operand matrix and a 3x3 B operand matrix in local register buffers. On start it clears the array, then streams skewed A rows into the west edge and B columns into the north edge, so that PE(i,j) accumulates C[i][j] = sum over k of A[i][k]*B[k][j]. It flags completion when every PE output holds its final value. The block sits between the host-side load path and the array, and owns the array's reset line.

## Interface
- DATAWIDTH, 8, operand width; matches the PE operand width.
- CLK  in  1  clock; all state changes on the rising edge.
- RSTn  in  1  synchronous active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_sel  in  1  buffer select: 0 = A, 1 = B.
- wr_addr  in  4  element index row*3+col, valid range 0..8.
- wr_data  in  DATAWIDTH  element value.
- start  in  1  request one matrix multiply.
- arr_rstn  out  1  registered active-low reset to all 9 PEs.
- a_west  out  3*DATAWIDTH  row i on bits [i*DW +: DW], drives PE(i,0) A input.
- b_north  out  3*DATAWIDTH  column j on bits [j*DW +: DW], drives PE(0,j) B input.
- busy  out  1  high in CLEAR and FEED.
- done  out  1  one-cycle pulse on completion.
- result_valid  out  1  PE_out of all PEs holds the final C.

## Operation
- FSM states: IDLE, CLEAR, FEED, DONE.
- IDLE:
  - start=1 -> CLEAR.
  - result_valid cleared when start is accepted.
- CLEAR (1 cycle):
  - arr_rstn=0; edge outputs 0.
  - Feed counter t set to 0.
  - Next state FEED.
- FEED, counter t = 0..6 (K+2N-2 = 7 cycles, K=N=3):
  - a_west[i] = A[i][t-i] when 0 <= t-i <= 2, else 0.
  - b_north[j] = B[t-j][j] when 0 <= t-j <= 2, else 0.
  - PE(i,j) therefore sees matching k = t-i-j.
  - t==6 -> DONE; otherwise t increments.
- DONE (1 cycle):
  - done=1; result_valid set; next state IDLE.
- result_valid holds 1 in IDLE until the next accepted start. The edges then carry zeros only, so the accumulators stay stable.
- Writes:
  - Accepted only in IDLE and DONE; ignored while busy.
  - wr_addr > 8 is ignored.
  - A write in the same cycle as an accepted start is stored, and the feed uses the new value.
- Outside FEED: a_west=0, b_north=0.
- arr_rstn=1 in every state except CLEAR and reset.
- start in any state other than IDLE is ignored; it is not queued.
- Arithmetic is owned by the PE: 2*DATAWIDTH+1-bit accumulator, wraps modulo 2^(2*DW+1). The scheduler does not saturate or detect overflow.

## Timing
- Reset values while RSTn=0 is sampled:
  - state IDLE, t=0.
  - All buffer entries 0.
  - a_west=0, b_north=0, busy=0, done=0, result_valid=0.
  - arr_rstn=0, so the array is held in reset.
- Reset asserted mid-operation aborts immediately. No done pulse is produced, and results are invalid.
- Cycle sequence, with start sampled at the edge ending cycle S:
  - S+1: CLEAR, busy=1, arr_rstn=0.
  - S+2..S+8: FEED t=0..6.
  - S+9: DONE, done=1, busy=0.
- The edge ending S+8 latches the final value into every PE. result_valid=1 from S+9 onward.
- Start-to-done latency is 9 cycles. Minimum back-to-back period is 10 cycles: start is earliest accepted in IDLE at S+10.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Identity test:
  - Load A=I, B=[1..9] row-major, pulse start.
  - Expect done at S+9.
  - Expect PE(i,j) = B[i][j] (1..9).
  - Expect the a_west/b_north skew sequence exactly as defined, including zeros at t=5,6 for row/column 0.
- General product:
  - Load A=[1..9], B=[9..1].
  - Expect C = [30,24,18; 84,69,54; 138,114,90].
  - Expect result_valid held until the next start.
- Overflow, DATAWIDTH=8:
  - All A and B elements = 255.
  - Every PE expects 195075 mod 131072 = 64003.
  - done timing unchanged.
- Ignored requests:
  - start at S+4 -> no restart, done still at S+9.
  - wr_en at S+5 -> buffer unchanged; verify by rerunning the multiply.
- Reset during FEED:
  - RSTn=0 at S+5.
  - Next cycle expect IDLE, arr_rstn=0, outputs 0, no done.
  - After release, a new start completes correctly.
- Back-to-back:
  - New B written in DONE cycle, start at S+10.
  - Expect the second result reflects the new B.
  - Expect the array cleared via arr_rstn at S+11.
